// File: rtl/alu_bist_seq.sv
// Self-test sequencer for the 3-bit sign-magnitude add_sub unit: sweeps all
// operand pairs for A+B and A-B, checks each result and streams one record per vector.
module alu_bist_seq #(
   parameter int unsigned SETTLE = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [6:0]  err_count,
   output logic        op_o,
   output logic [2:0]  a_o,
   output logic [2:0]  b_o,
   input  logic [3:0]  r_i,
   input  logic        sf_i,
   input  logic        zf_i,
   input  logic        dzf_i,
   output logic        rec_valid,
   input  logic        rec_ready,
   output logic [14:0] rec_data
);

   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_EMIT, S_DONE} state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
   localparam logic [2:0] IDX_LAST    = 3'd6;

   state_t       state_q, state_d;
   logic         op_q, op_d;
   logic [2:0]   ia_q, ia_d, ib_q, ib_d;
   logic [2:0]   a_q, a_d, b_q, b_d;
   logic [3:0]   settle_q, settle_d;
   logic [6:0]   err_q, err_d;
   logic [14:0]  rec_q, rec_d;

   logic         start_acc, sample, xfer, last_vec;
   logic         nxt_op;
   logic [2:0]   nxt_ia, nxt_ib;
   logic signed [4:0] va, vb, s;
   logic [2:0]   s_mag;
   logic [3:0]   r_exp;
   logic         mismatch;

   // Index 0..6 maps to value -3..+3; negative zero is never produced.
   function automatic logic [2:0] enc(input logic [2:0] idx);
      if (idx < 3'd3) begin
         enc = {1'b1, 2'(3'd3 - idx)};
      end else begin
         enc = {1'b0, 2'(idx - 3'd3)};
      end
   endfunction

   assign start_acc = start && ((state_q == S_IDLE) || (state_q == S_DONE));
   assign sample    = (state_q == S_DRIVE) && (settle_q == SETTLE_LAST);
   assign xfer      = (state_q == S_EMIT) && rec_ready;
   assign last_vec  = op_q && (ia_q == IDX_LAST) && (ib_q == IDX_LAST);

   always_comb begin
      nxt_op = op_q;
      nxt_ia = ia_q;
      nxt_ib = ib_q + 3'd1;
      if (ib_q == IDX_LAST) begin
         nxt_ib = 3'd0;
         nxt_ia = ia_q + 3'd1;
         if (ia_q == IDX_LAST) begin
            nxt_ia = 3'd0;
            nxt_op = 1'b1;
         end
      end
   end

   always_comb begin
      va       = $signed({2'b00, ia_q}) - 5'sd3;
      vb       = $signed({2'b00, ib_q}) - 5'sd3;
      s        = op_q ? (va - vb) : (va + vb);
      s_mag    = s[4] ? 3'(-s) : s[2:0];
      r_exp    = {s[4], s_mag};
      mismatch = (r_i != r_exp) || (sf_i != s[4]) ||
                 (zf_i != (s == 5'sd0)) || dzf_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         op_q     <= 1'b0;
         ia_q     <= 3'd0;
         ib_q     <= 3'd0;
         a_q      <= 3'd0;
         b_q      <= 3'd0;
         settle_q <= 4'd0;
         err_q    <= 7'd0;
         rec_q    <= 15'd0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         ia_q     <= ia_d;
         ib_q     <= ib_d;
         a_q      <= a_d;
         b_q      <= b_d;
         settle_q <= settle_d;
         err_q    <= err_d;
         rec_q    <= rec_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DONE: if (start_acc) state_d = S_DRIVE;
         S_DRIVE:        if (sample)    state_d = S_EMIT;
         S_EMIT:         if (xfer)      state_d = last_vec ? S_DONE : S_DRIVE;
         default:                       state_d = S_IDLE;
      endcase
   end

   // Operands only move on DRIVE entry, so they stay put through EMIT and DONE.
   always_comb begin
      op_d     = op_q;
      ia_d     = ia_q;
      ib_d     = ib_q;
      a_d      = a_q;
      b_d      = b_q;
      settle_d = settle_q;
      err_d    = err_q;
      rec_d    = rec_q;
      if (start_acc) begin
         op_d     = 1'b0;
         ia_d     = 3'd0;
         ib_d     = 3'd0;
         a_d      = enc(3'd0);
         b_d      = enc(3'd0);
         settle_d = 4'd0;
         err_d    = 7'd0;
      end else if (state_q == S_DRIVE) begin
         if (sample) begin
            rec_d = {mismatch, op_q, a_q, b_q, r_i, sf_i, zf_i, dzf_i};
            if (mismatch && (err_q != 7'h7f)) err_d = err_q + 7'd1;
         end else begin
            settle_d = settle_q + 4'd1;
         end
      end else if (xfer && !last_vec) begin
         op_d     = nxt_op;
         ia_d     = nxt_ia;
         ib_d     = nxt_ib;
         a_d      = enc(nxt_ia);
         b_d      = enc(nxt_ib);
         settle_d = 4'd0;
      end
   end

   always_comb begin
      busy      = (state_q == S_DRIVE) || (state_q == S_EMIT);
      done      = (state_q == S_DONE);
      pass      = (state_q == S_DONE) && (err_q == 7'd0);
      rec_valid = (state_q == S_EMIT);
   end

   assign err_count = err_q;
   assign op_o      = op_q;
   assign a_o       = a_q;
   assign b_o       = b_q;
   assign rec_data  = rec_q;

endmodule

// File: doc/alu_bist_seq.md
# alu_bist_seq

Hardware self-test sequencer for the 3-bit sign-magnitude `add_sub` unit. It drives every operand pair for both operations into `add_sub` and samples R/SF/ZF/DZF after a settle delay. Each sample is compared against an internally computed expected result and emitted as one record on a valid/ready stream, ending with an error count and a pass flag. It sits between `add_sub` and the debug/log path, and doubles as power-on self-test for the ALU.

## Interface
- `SETTLE`, default 1: cycles operands are held before the result is sampled; legal range 1..15.
- `clk`  in  1  clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to run a sweep; ignored while `busy`=1.
- `busy`  out  1  sweep in progress.
- `done`  out  1  sweep finished; held until next accepted `start` or reset.
- `pass`  out  1  `done` && `err_count`==0.
- `err_count`  out  7  number of mismatching vectors in current/last sweep.
- `op_o`  out  1  to `add_sub` OP: 0 = A+B, 1 = A−B.
- `a_o`, `b_o`  out  3 each  to `add_sub` A/B: {sign, mag[1:0]}.
- `r_i`  in  4  from `add_sub` R: {sign, mag[2:0]}.
- `sf_i`, `zf_i`, `dzf_i`  in  1 each  flags from `add_sub`.
- `rec_valid`  out  1  record available.
- `rec_ready`  in  1  consumer accepts record.
- `rec_data`  out  15  {mismatch, op, a[2:0], b[2:0], r[3:0], sf, zf, dzf}; r and flags are the sampled DUT values.

## Operation
- Operand encoding: value v in −3..+3 → {v<0, |v|[1:0]}; −0 (100) is never driven.
- Sweep order: op 0 then op 1. Within each op, A outer −3..+3, B inner −3..+3. That gives 49 vectors per op, 98 total.
- Internal counters: op bit, ia/ib in 0..6; operand value = idx − 3.
- Expected result s = a±b, range −6..+6. r_exp = {s<0, |s|[2:0]}; zero is always 0000.
- Expected flags: sf_exp = (s<0), zf_exp = (s==0), dzf_exp = 0.
- mismatch = any of r_i, sf_i, zf_i, dzf_i differs from expected. On mismatch `err_count` increments, saturating at 127.
- FSM states: IDLE, DRIVE, EMIT, DONE.
  - IDLE/DONE + `start` → DRIVE. Counters, `err_count` and settle counter clear; `done` clears.
  - DRIVE: hold op_o/a_o/b_o for `SETTLE` cycles. At the end of the SETTLE-th cycle, register DUT outputs plus mismatch into `rec_data` → EMIT.
  - EMIT: `rec_valid`=1 with `rec_data` stable until `rec_valid`&&`rec_ready` at a clock edge.
    - On transfer of a non-final vector: advance counters and go to DRIVE, with new operands driven from that edge.
    - On transfer of vector 98 → DONE.
  - DONE: `done`=1, `busy`=0, operands hold the last vector.
- `busy` = state ∈ {DRIVE, EMIT}.
- Operand outputs are registered and change only on a DRIVE entry edge.

## Timing
- Reset (async, any state): state IDLE, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `op_o`=0, `a_o`=`b_o`=000, `rec_valid`=0, `rec_data`=0.
- A record in flight at reset is dropped; no partial sweep state survives.
- Start sampled at edge 0 (IDLE): `busy`=1 and vector 1 operands driven after edge 0.
- With `SETTLE`=1 and `rec_ready` tied 1, vector k occupies cycles 2k−1 (DRIVE) and 2k (EMIT).
  - `rec_valid` is high for cycle 2k; the transfer happens at edge 2k.
  - `done`=1 and `busy`=0 after edge 196.
- General case: per-vector latency = `SETTLE` + 1 + (stall cycles where `rec_ready`=0).
- Backpressure: while `rec_valid`=1 and `rec_ready`=0, all outputs are held. `rec_ready` while `rec_valid`=0 has no effect.
- `start` while busy: ignored, with no change in any output.
- `start` in DONE: behaves as from IDLE.
- `err_count` updates at the sample edge (DRIVE→EMIT), not at transfer.

## Test plan
- Reset mid-sweep: assert `rst_n`=0 during EMIT of vector 10 → all outputs at reset values asynchronously. `start` after release → first record is op=0, a=111, b=111.
- Ideal `add_sub` model, `SETTLE`=1, `rec_ready`=1 → 98 records; `done` at edge 196; `err_count`=0; `pass`=1.
  - Record op=0, a=001, b=111 shows r=1010, sf=1, zf=0.
  - Record op=1, a=110, b=110 shows r=0000, zf=1.
  - Record op=1, a=011, b=111 shows r=0110.
- Fault injection: force `dzf_i`=1 for the op=1 half only → exactly 49 records with mismatch=1; `err_count`=49; `pass`=0.
- Backpressure: random `rec_ready` at 30% duty → `rec_data` stable while stalled; record order matches sweep order; still 98 records.
- `SETTLE`=3: DUT model with 2-cycle output latency → zero mismatches. Same model with `SETTLE`=1 → nonzero `err_count`.
- `start` pulsed while busy → ignored. `start` in DONE → `err_count` and `done` clear; sweep repeats identically.
